// File: rtl/ledmux_scan_ctrl.sv
// Column-scan sequencer for the X/Y 8x8 LED panels with a double-buffered frame.
// Bytes from the SPI receiver fill the back buffer; it is promoted to the front only at a scan wrap.
module ledmux_scan_ctrl #(
  parameter int unsigned DWELL  = 16384,
  parameter int unsigned NBYTES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [7:0] row,
  output logic [7:0] colx,
  output logic [7:0] coly,
  output logic       frame_ack,
  output logic       overrun
);

  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // Byte i of the frame sits at element i, so element 0 is bits 127:120 (X column 0).
  logic [0:NBYTES-1][7:0] front_q, back_q;
  logic                   pending_q;
  logic [IW-1:0]          wr_idx_q, wr_sel;
  logic                   accept;

  state_t        state_q, state_d;
  logic [IW-1:0] col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          swap;
  logic [7:0]    row_d, colx_d, coly_d;

  // ---------------------------------------------------------------------------
  // Scan FSM: next state and the output values that go with it
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    swap    = 1'b0;

    unique case (state_q)
      IDLE: begin
        swap = pending_q;
        if (enable) begin
          state_d = BLANK;
          col_d   = '0;
        end
      end
      BLANK: begin
        state_d = DRIVE;
        dwell_d = '0;
      end
      DRIVE: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == DWELL_LAST) begin
          state_d = BLANK;
          col_d   = col_q + 1'b1;
          // A frame that completed on this very edge is not yet in pending_q, so it waits a scan.
          swap    = pending_q && (col_q == IDX_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      col_d   = '0;
      dwell_d = '0;
      if (state_q != IDLE) swap = 1'b0;
    end

    // Outputs are registered, so decode them from the state being entered.
    row_d  = '0;
    colx_d = '0;
    coly_d = '0;
    if (state_d == DRIVE) begin
      row_d = front_q[col_d];
      if (!col_d[3]) colx_d = 8'd1 << col_d[2:0];
      else           coly_d = 8'd1 << col_d[2:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      dwell_q   <= '0;
      row       <= '0;
      colx      <= '0;
      coly      <= '0;
      frame_ack <= 1'b0;
      front_q   <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      row       <= row_d;
      colx      <= colx_d;
      coly      <= coly_d;
      frame_ack <= swap;
      if (swap) front_q <= back_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path: fill the back buffer, flag a complete frame, detect overrun
  // ---------------------------------------------------------------------------
  assign wr_sel = frame_start ? '0 : wr_idx_q;
  assign accept = byte_valid && !pending_q;

  // NOTE: both frame buffers are reset explicitly; a reset must leave a blank display, not stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      back_q    <= '0;
      wr_idx_q  <= '0;
      pending_q <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        back_q[wr_sel] <= byte_data;
        wr_idx_q       <= wr_sel + 1'b1;
        if (wr_sel == IDX_LAST) pending_q <= 1'b1;
      end else if (frame_start) begin
        wr_idx_q <= '0;
      end

      // swap and accept never coincide: one needs pending set, the other clear.
      if (swap) pending_q <= 1'b0;

      if (byte_valid && pending_q) overrun <= 1'b1;
      else if (frame_start)        overrun <= 1'b0;
    end
  end

endmodule
